axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_pkg.sv | 34 +++
 rtl/axil_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the command master: FSM states,
// response codes, protection constant and the saturating error-count step.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT = 3'b000;

    localparam int ERR_CNT_W = 16;

    // Count every non-OKAY response, sticking at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_step(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [1:0]           resp
    );
        if ((resp != RESP_OKAY) && (cnt != {ERR_CNT_W{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that turns a simple valid/ready command into one AXI
// transaction at a time and returns the read data / response code.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_addr_i,
    input  logic [DW-1:0]     cmd_wdata_i,
    input  logic [DW/8-1:0]   cmd_wstrb_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,

    output logic [AW-1:0]     awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,

    output logic [DW-1:0]     wdata_o,
    output logic [DW/8-1:0]   wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,

    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,

    output logic [AW-1:0]     araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,

    input  logic [DW-1:0]     rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,

    output logic [2:0]        awprot_o,
    output logic [2:0]        arprot_o,

    output logic              busy_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_t                 state_reg;
    logic                   cmd_ready_reg;
    logic                   awvalid_reg;
    logic                   wvalid_reg;
    logic                   bready_reg;
    logic                   arvalid_reg;
    logic                   rready_reg;
    logic                   rsp_valid_reg;
    logic [AW-1:0]          addr_reg;
    logic [DW-1:0]          wdata_reg;
    logic [DW/8-1:0]        wstrb_reg;
    logic [DW-1:0]          rdata_reg;
    logic [1:0]             resp_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;

    // A write channel is finished once its valid has already dropped or it
    // handshakes this cycle; AW and W may complete in any order.
    logic aw_done_next;
    logic w_done_next;

    assign aw_done_next = !awvalid_reg || awready_i;
    assign w_done_next  = !wvalid_reg  || wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rdata_reg     <= '0;
            resp_reg      <= '0;
            err_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Ready rises one cycle after entering IDLE, so the
                    // cycle returning from RSP never accepts a command.
                    if (cmd_ready_reg && cmd_valid_i) begin
                        cmd_ready_reg <= 1'b0;
                        addr_reg      <= cmd_addr_i;
                        wdata_reg     <= cmd_wdata_i;
                        wstrb_reg     <= cmd_wstrb_i;
                        if (cmd_we_i) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_WR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_RA;
                        end
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end

                ST_WR: begin
                    if (awready_i) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (wready_i) begin
                        wvalid_reg <= 1'b0;
                    end
                    if (aw_done_next && w_done_next) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_WB;
                    end
                end

                ST_WB: begin
                    if (bready_reg && bvalid_i) begin
                        bready_reg    <= 1'b0;
                        rdata_reg     <= '0;
                        resp_reg      <= bresp_i;
                        err_cnt_reg   <= err_cnt_step(err_cnt_reg, bresp_i);
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RSP;
                    end
                end

                ST_RA: begin
                    if (arready_i) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_RD;
                    end
                end

                ST_RD: begin
                    if (rready_reg && rvalid_i) begin
                        rready_reg    <= 1'b0;
                        rdata_reg     <= rdata_i;
                        resp_reg      <= rresp_i;
                        err_cnt_reg   <= err_cnt_step(err_cnt_reg, rresp_i);
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_rdata_o = rdata_reg;
    assign rsp_resp_o  = resp_reg;

    assign awaddr_o  = addr_reg;
    assign awvalid_o = awvalid_reg;
    assign wdata_o   = wdata_reg;
    assign wstrb_o   = wstrb_reg;
    assign wvalid_o  = wvalid_reg;
    assign bready_o  = bready_reg;
    assign araddr_o  = addr_reg;
    assign arvalid_o = arvalid_reg;
    assign rready_o  = rready_reg;

    assign awprot_o = AXI_PROT;
    assign arprot_o = AXI_PROT;

    assign busy_o    = (state_reg != ST_IDLE);
    assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: configurable AXI-Lite slave, response
// scoreboard with per-cycle protocol checks, and literal expectations per test.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i       = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i    = 1'b0;
    logic [AW-1:0] cmd_addr_i  = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic [SW-1:0] cmd_wstrb_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic [1:0]    rsp_resp_o;
    logic [AW-1:0] awaddr_o;
    logic          awvalid_o;
    logic          awready_i;
    logic [DW-1:0] wdata_o;
    logic [SW-1:0] wstrb_o;
    logic          wvalid_o;
    logic          wready_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i;
    logic          bready_o;
    logic [AW-1:0] araddr_o;
    logic          arvalid_o;
    logic          arready_i;
    logic [DW-1:0] rdata_i;
    logic [1:0]    rresp_i;
    logic          rvalid_i;
    logic          rready_o;
    logic [2:0]    awprot_o;
    logic [2:0]    arprot_o;
    logic          busy_o;
    logic [15:0]   err_cnt_o;

    axil_cmd_master #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awprot_o(awprot_o), .arprot_o(arprot_o),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    // Slave configuration and state
    int          cfg_aw_delay = 0;
    int          cfg_w_delay  = 0;
    int          cfg_ar_delay = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic [31:0] cfg_rdata    = '0;
    logic        cfg_b_block  = 1'b0;
    logic        spur         = 1'b0;

    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_count = 0;
    logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic bvalid_s = 1'b0, rvalid_s = 1'b0;

    assign awready_i = awvalid_o && (aw_cnt >= cfg_aw_delay);
    assign wready_i  = wvalid_o  && (w_cnt  >= cfg_w_delay);
    assign arready_i = arvalid_o && (ar_cnt >= cfg_ar_delay);
    assign bvalid_i  = bvalid_s | spur;
    assign rvalid_i  = rvalid_s | spur;
    assign bresp_i   = cfg_bresp;
    assign rresp_i   = cfg_rresp;
    assign rdata_i   = cfg_rdata;

    // Registered slave: B/R are raised the cycle after the address/data are recorded.
    initial begin : slave
        logic r, awh, wh, bh, arh, rh, awv, wv, arv;
        forever begin
            @(posedge clk);
            r   = rst_i;
            awv = awvalid_o; wv = wvalid_o; arv = arvalid_o;
            awh = awvalid_o && awready_i;
            wh  = wvalid_o && wready_i;
            arh = arvalid_o && arready_i;
            bh  = bvalid_i && bready_o;
            rh  = rvalid_i && rready_o;
            #1;
            if (r) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
                bvalid_s = 1'b0; rvalid_s = 1'b0;
            end else begin
                aw_cnt = (awv && !awh) ? aw_cnt + 1 : 0;
                w_cnt  = (wv && !wh)   ? w_cnt + 1  : 0;
                ar_cnt = (arv && !arh) ? ar_cnt + 1 : 0;
                if (bh) begin
                    bvalid_s = 1'b0;
                    b_count++;
                end else if (aw_got && w_got && !cfg_b_block) begin
                    bvalid_s = 1'b1;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (awh) aw_got = 1'b1;
                if (wh)  w_got  = 1'b1;
                if (rh) begin
                    rvalid_s = 1'b0;
                end else if (ar_got) begin
                    rvalid_s = 1'b1;
                    ar_got = 1'b0;
                end
                if (arh) ar_got = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_err = 0;
    int   split_cycles = 0;
    int   txn_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the scoreboard and the handshake rules.
    logic        prev_rst = 1'b0, seen = 1'b0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rspv = 0, p_rspr = 0;
    logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0, p_rd = 0;
    logic [3:0]  p_ws = 0;
    logic [1:0]  p_rs = 0;

    always @(negedge clk) begin
        logic wr_out, rd_out;
        if (prev_rst) begin
            exp_q.delete();
            model_err = 0;
            seen = 1'b0;
            check("reset_ctrl", {cmd_ready_o, busy_o, awvalid_o, wvalid_o, bready_o,
                                 arvalid_o, rready_o, rsp_valid_o, rsp_resp_o}, 64'd0);
            check("reset_payload", |{awaddr_o, araddr_o, wdata_o, wstrb_o, rsp_rdata_o, err_cnt_o}, 64'd0);
        end else begin
            if (p_rspv && p_rspr) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                seen = 1'b0;
                check("return_cycle", {cmd_ready_o, busy_o}, 64'd0);
            end
            check("prot_const", {awprot_o, arprot_o}, 64'd0);
            check("ready_only_idle", cmd_ready_o && busy_o, 64'd0);
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (exp_q[0].resp != RESP_OKAY && model_err < 65535) model_err++;
                    end
                    check("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
                    check("rsp_resp", rsp_resp_o, exp_q[0].resp);
                end
            end
            check("err_cnt", err_cnt_o, model_err);
            if ((awvalid_o && !p_awv) || (wvalid_o && !p_wv))
                check("aw_w_together", {awvalid_o, wvalid_o, p_awv, p_wv}, 64'b1100);
            if (p_awv && !p_awr) check("aw_hold", {awvalid_o, awaddr_o}, {1'b1, p_awa});
            if (p_awv && p_awr)  check("aw_drop", awvalid_o, 0);
            if (p_wv && !p_wr)   check("w_hold", {wvalid_o, wdata_o, wstrb_o}, {1'b1, p_wd, p_ws});
            if (p_wv && p_wr)    check("w_drop", wvalid_o, 0);
            if (p_arv && !p_arr) check("ar_hold", {arvalid_o, araddr_o}, {1'b1, p_ara});
            if (p_arv && p_arr)  check("ar_drop", arvalid_o, 0);
            if (p_rspv && !p_rspr)
                check("rsp_hold", {rsp_valid_o, rsp_rdata_o, rsp_resp_o}, {1'b1, p_rd, p_rs});
            wr_out = (exp_q.size() > 0) ? exp_q[0].we : 1'b0;
            rd_out = (exp_q.size() > 0) ? !exp_q[0].we : 1'b0;
            if (bready_o) check("bready_phase", {awvalid_o || wvalid_o, rsp_valid_o, wr_out}, 64'b001);
            if (rready_o) check("rready_phase", {arvalid_o, rsp_valid_o, rd_out}, 64'b001);
            if (awvalid_o && !wvalid_o) split_cycles++;
        end
        p_awv = awvalid_o; p_awr = awready_i; p_awa = awaddr_o;
        p_wv = wvalid_o; p_wr = wready_i; p_wd = wdata_o; p_ws = wstrb_o;
        p_arv = arvalid_o; p_arr = arready_i; p_ara = araddr_o;
        p_rspv = rsp_valid_o; p_rspr = rsp_ready_i; p_rd = rsp_rdata_o; p_rs = rsp_resp_o;
        prev_rst = rst_i;
    end

    // Call one time unit after a rising edge.
    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        exp_t e;
        logic ok;
        ok = 1'b0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr;
        cmd_wdata_i = wdata; cmd_wstrb_i = strb;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("cmd_accept_timeout", 0, 1);
        end else begin
            e.we    = we;
            e.rdata = we ? 32'd0 : cfg_rdata;
            e.resp  = we ? cfg_bresp : cfg_rresp;
            exp_q.push_back(e);
        end
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] rd, output logic [1:0] rs,
                           output int lat);
        logic found;
        found = 1'b0; lat = 0; rd = '0; rs = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = i;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check("rsp_timeout", 0, 1);
        end else begin
            rd = rsp_rdata_o;
            rs = rsp_resp_o;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_rsp", {rsp_valid_o, cmd_ready_o, busy_o, rsp_resp_o, rsp_rdata_o},
                      {1'b1, 1'b0, 1'b1, rs, rd});
            end
            @(posedge clk); #1 rsp_ready_i = 1'b1;
            @(posedge clk); #1 rsp_ready_i = 1'b0;
        end
        txn_no++;
        $display("txn %0d: rdata=%08h resp=%0d latency=%0d", txn_no, rd, rs, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat;
        logic        hit;

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {busy_o, err_cnt_o}, 64'd0);
        @(posedge clk); #1;

        // Zero-wait write: addr 0x04, data 1
        b_count = 0;
        send_cmd(1'b1, 32'h4, 32'h1, 4'hF);
        get_rsp(0, rd, rs, lat);
        check("wr_latency", lat, 4);
        check("wr_rdata", rd, 32'h0);
        check("wr_resp", rs, 2'b00);
        check("wr_b_count", b_count, 1);

        // Read of addr 0x00 returning A5A5A5A5
        cfg_rdata = 32'hA5A5_A5A5;
        send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
        get_rsp(0, rd, rs, lat);
        check("rd_rdata", rd, 32'hA5A5_A5A5);
        check("rd_resp", rs, 2'b00);
        check("rd_latency", lat, 4);

        // W accepted 3 cycles before AW
        cfg_aw_delay = 3; cfg_w_delay = 0;
        split_cycles = 0; b_count = 0;
        send_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'h3);
        get_rsp(0, rd, rs, lat);
        check("split_aw_held_cycles", split_cycles, 3);
        check("split_b_count", b_count, 1);
        check("split_resp", rs, 2'b00);
        cfg_aw_delay = 0;

        // Error responses pass through and are counted
        cfg_rresp = RESP_SLVERR; cfg_rdata = 32'h0BAD_0BAD;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
        get_rsp(0, rd, rs, lat);
        check("rd_slverr_resp", rs, 2'b10);
        check("rd_slverr_data", rd, 32'h0BAD_0BAD);
        cfg_rresp = RESP_OKAY;
        cfg_bresp = RESP_DECERR;
        send_cmd(1'b1, 32'h24, 32'h7, 4'h1);
        get_rsp(0, rd, rs, lat);
        check("wr_decerr_resp", rs, 2'b11);
        check("wr_decerr_data", rd, 32'h0);
        cfg_bresp = RESP_OKAY;
        @(negedge clk);
        check("err_cnt_two", err_cnt_o, 2);
        @(posedge clk); #1;

        // Response back-pressure for 10 cycles
        cfg_rdata = 32'h1234_5678;
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
        get_rsp(10, rd, rs, lat);
        check("bp_rdata", rd, 32'h1234_5678);

        // Spurious B/R while idle must be ignored
        cfg_bresp = RESP_DECERR; cfg_rresp = RESP_DECERR;
        @(posedge clk); #1 spur = 1'b1;
        repeat (3) @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        check("spurious_ignored", {busy_o, rsp_valid_o, err_cnt_o}, {1'b0, 1'b0, 16'd2});
        cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;
        @(posedge clk); #1;

        // Reset while waiting in WB, then a clean read
        cfg_b_block = 1'b1;
        send_cmd(1'b1, 32'h10, 32'h55, 4'hF);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bready_o) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_wb", hit, 1);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        cfg_b_block = 1'b0;
        @(negedge clk);
        check("rst_wb_outputs", {busy_o, bready_o, rsp_valid_o, err_cnt_o}, 64'd0);
        @(posedge clk); #1;
        cfg_rdata = 32'hCAFE_F00D;
        send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
        get_rsp(0, rd, rs, lat);
        check("post_rst_rdata", rd, 32'hCAFE_F00D);
        check("post_rst_resp", rs, 2'b00);
        check("post_rst_latency", lat, 4);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
